// File: rtl/reg_serial_tx_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : reg_serial_tx_pkg                                              |
// | Brief    : Shared state encoding, defaults and helpers for reg_serial_tx. |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
package reg_serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DIV   = 1;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_serial_bit_timer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : reg_serial_bit_timer                                           |
// | Brief    : Per-bit divide counter; yields bit strobe and advance pulse.   |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module reg_serial_bit_timer
  import reg_serial_tx_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic clr_n,
  input  logic start_i,
  input  logic abort_i,
  input  logic run_i,
  input  logic last_bit_i,
  output logic bit_adv_o,
  output logic bit_strobe_o
);

  localparam int DCW = cnt_width(DIV);

  logic [DCW-1:0] div_cnt_q;
  logic [DCW-1:0] div_cnt_d;
  logic           bit_strobe_q;
  logic           bit_strobe_d;

  assign bit_adv_o    = run_i & (div_cnt_q == DCW'(DIV - 1));
  assign bit_strobe_o = bit_strobe_q;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (start_i || abort_i) begin
      div_cnt_d = '0;
    end else if (run_i) begin
      div_cnt_d = bit_adv_o ? '0 : div_cnt_q + DCW'(1);
    end
    // Strobe marks the first cycle of each bit, none after the final bit.
    bit_strobe_d = start_i | (bit_adv_o & ~last_bit_i & ~abort_i);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_cnt_q    <= '0;
      bit_strobe_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bit_strobe_q <= bit_strobe_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_serial_tx.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : reg_serial_tx                                                  |
// | Brief    : Parallel-in, serial-out word transmitter with handshake.       |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module reg_serial_tx
  import reg_serial_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DIV       = DEFAULT_DIV,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_valid,
  output logic             write_ready,
  input  logic             abort,
  output logic             serial_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  localparam int BCW = cnt_width(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic             serial_q;
  logic             done_q;

  logic             accept;
  logic             bit_adv;
  logic             last_bit;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] shift_nx;

  assign write_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy        = (state_q == ST_SHIFT);
  assign accept      = write_valid & write_ready;
  assign last_bit    = (bit_cnt_q == BCW'(WIDTH - 1));
  assign serial_out  = serial_q;
  assign done        = done_q;

  // shift_q holds only the bits not yet presented on serial_out.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign first_bit = write_data[0];
      assign load_val  = {1'b0, write_data[WIDTH-1:1]};
      assign next_bit  = shift_q[0];
      assign shift_nx  = {1'b0, shift_q[WIDTH-1:1]};
    end else begin : g_msb_first
      assign first_bit = write_data[WIDTH-1];
      assign load_val  = {write_data[WIDTH-2:0], 1'b0};
      assign next_bit  = shift_q[WIDTH-1];
      assign shift_nx  = {shift_q[WIDTH-2:0], 1'b0};
    end
  endgenerate

  reg_serial_bit_timer #(
    .DIV (DIV)
  ) u_timer (
    .clk          (clk),
    .clr_n        (clr_n),
    .start_i      (accept),
    .abort_i      (abort),
    .run_i        (busy),
    .last_bit_i   (last_bit),
    .bit_adv_o    (bit_adv),
    .bit_strobe_o (bit_strobe)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state_q   <= ST_SHIFT;
            shift_q   <= load_val;
            bit_cnt_q <= '0;
            serial_q  <= first_bit;
          end else begin
            state_q  <= ST_IDLE;
            serial_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // Abort outranks the final-bit move to DONE.
          if (abort) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            serial_q  <= 1'b0;
          end else if (bit_adv) begin
            if (last_bit) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              serial_q <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
              shift_q   <= shift_nx;
              serial_q  <= next_bit;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          bit_cnt_q <= '0;
          serial_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_serial_tx.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_reg_serial_tx                                               |
// | Brief    : Self-checking bench for two reg_serial_tx configurations.      |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module tb_reg_serial_tx;

  localparam int W     = 32;
  localparam int DIV_A = 1;
  localparam int DIV_B = 3;
  localparam bit LSB_A = 1'b1;
  localparam bit LSB_B = 1'b0;

  logic         clk   = 1'b0;
  logic         clr_n = 1'b0;
  logic [W-1:0] wdata   [2];
  logic         wvalid  [2];
  logic         abort_s [2];
  logic         wready  [2];
  logic         so      [2];
  logic         st      [2];
  logic         busy    [2];
  logic         done    [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int done_cyc [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_serial_tx #(.WIDTH(W), .DIV(DIV_A), .LSB_FIRST(LSB_A)) dut_a (
    .clk (clk), .clr_n (clr_n),
    .write_data (wdata[0]), .write_valid (wvalid[0]), .write_ready (wready[0]),
    .abort (abort_s[0]), .serial_out (so[0]), .bit_strobe (st[0]),
    .busy (busy[0]), .done (done[0])
  );

  reg_serial_tx #(.WIDTH(W), .DIV(DIV_B), .LSB_FIRST(LSB_B)) dut_b (
    .clk (clk), .clr_n (clr_n),
    .write_data (wdata[1]), .write_valid (wvalid[1]), .write_ready (wready[1]),
    .abort (abort_s[1]), .serial_out (so[1]), .bit_strobe (st[1]),
    .busy (busy[1]), .done (done[1])
  );

  function automatic int div_of(input int s);
    return (s == 0) ? DIV_A : DIV_B;
  endfunction

  // Bit on the line for the i-th transmitted position.
  function automatic logic model_bit(input int s, input logic [W-1:0] w, input int i);
    if ((s == 0) ? LSB_A : LSB_B) return w[i];
    else return w[W-1-i];
  endfunction

  task automatic accept(input int s, input logic [W-1:0] word, input logic ab);
    @(negedge clk);
    checks++;
    if (wready[s] !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_accept sel=%0d got=%b want=1", s, wready[s]);
    end
    wdata[s]   = word;
    wvalid[s]  = 1'b1;
    abort_s[s] = ab;
    @(posedge clk);
    #1;
    wvalid[s]  = 1'b0;
    abort_s[s] = 1'b0;
  endtask

  // Checks every cycle from the first bit through the DONE cycle.
  task automatic check_transfer(input int s, input logic [W-1:0] word, input bit keep,
                                input bit chain, input logic [W-1:0] nxt, input int abort_at);
    int d, wd;
    logic [4:0] obs, exp_v;
    logic ebit;
    bit sh;
    d  = div_of(s);
    wd = W * d;
    for (int j = 1; j <= wd + 1; j++) begin
      @(negedge clk);
      sh   = (j <= wd);
      ebit = 1'b0;
      if (sh) ebit = model_bit(s, word, (j - 1) / d);
      exp_v = {ebit, sh && (((j - 1) % d) == 0), sh, !sh, !sh};
      obs   = {so[s], st[s], busy[s], wready[s], done[s]};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL xfer sel=%0d word=%h j=%0d got=%b want=%b (serial,strobe,busy,ready,done)",
                 s, word, j, obs, exp_v);
      end
      if (!sh) done_cyc[s] = cyc;
      if (j == abort_at) begin
        abort_s[s] = 1'b1;
        @(posedge clk);
        #1;
        abort_s[s] = 1'b0;
        wvalid[s]  = 1'b0;
        return;
      end
      if (keep && j < wd) begin
        wvalid[s] = 1'b1;
        wdata[s]  = $urandom;
      end else if (chain && j >= wd) begin
        wvalid[s] = 1'b1;
        wdata[s]  = nxt;
      end else begin
        wvalid[s] = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input int s, input int n, input string tag);
    logic [4:0] obs;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs = {so[s], st[s], busy[s], wready[s], done[s]};
      checks++;
      if (obs !== 5'b00010) begin
        errors++;
        $display("FAIL %s sel=%0d cyc=%0d got=%b want=00010", tag, s, i, obs);
      end
    end
  endtask

  task automatic test_reset;
    logic [4:0] obs;
    #2;
    for (int s = 0; s < 2; s++) begin
      obs = {so[s], st[s], busy[s], wready[s], done[s]};
      checks++;
      if (obs !== 5'b00010) begin
        errors++;
        $display("FAIL reset sel=%0d got=%b want=00010", s, obs);
      end
    end
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    check_idle(0, 2, "post_reset");
    check_idle(1, 1, "post_reset");
  endtask

  task automatic test_single;
    accept(0, 32'hA5A5_0F0F, 1'b0);
    check_transfer(0, 32'hA5A5_0F0F, 1'b0, 1'b0, '0, 0);
    check_idle(0, 2, "after_single");
  endtask

  task automatic test_div3;
    accept(1, 32'h8000_0001, 1'b0);
    check_transfer(1, 32'h8000_0001, 1'b0, 1'b0, '0, 0);
    check_idle(1, 2, "after_div3");
  endtask

  task automatic test_random;
    logic [W-1:0] w;
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      accept(i % 2, w, 1'b0);
      check_transfer(i % 2, w, bit'($urandom_range(0, 1)), 1'b0, '0, 0);
    end
  endtask

  task automatic test_valid_held;
    logic [W-1:0] w;
    for (int s = 0; s < 2; s++) begin
      w = $urandom;
      accept(s, w, 1'b0);
      check_transfer(s, w, 1'b1, 1'b0, '0, 0);
      check_idle(s, 1, "after_held");
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] w;
    int t1;
    for (int s = 0; s < 2; s++) begin
      w = $urandom;
      accept(s, w, 1'b0);
      check_transfer(s, w, 1'b0, 1'b1, 32'hFFFF_FFFF, 0);
      t1 = done_cyc[s];
      check_transfer(s, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 0);
      checks++;
      if (done_cyc[s] - t1 !== W * div_of(s) + 1) begin
        errors++;
        $display("FAIL b2b_done_gap sel=%0d got=%0d want=%0d", s, done_cyc[s] - t1,
                 W * div_of(s) + 1);
      end
      check_idle(s, 1, "after_b2b");
    end
  endtask

  task automatic test_abort;
    logic [W-1:0] w;
    accept(0, 32'h1234_5678, 1'b0);
    check_transfer(0, 32'h1234_5678, 1'b0, 1'b0, '0, 10);
    check_idle(0, 4, "abort_mid");
    w = $urandom;
    accept(0, w, 1'b0);
    check_transfer(0, w, 1'b0, 1'b0, '0, 0);
    // Abort on the last bit cycle beats the move to DONE.
    w = $urandom;
    accept(0, w, 1'b0);
    check_transfer(0, w, 1'b0, 1'b0, '0, W * DIV_A);
    check_idle(0, 3, "abort_last");
    w = $urandom;
    accept(1, w, 1'b0);
    check_transfer(1, w, 1'b0, 1'b0, '0, int'($urandom_range(1, W * DIV_B)));
    check_idle(1, 4, "abort_div3");
    w = $urandom;
    accept(1, w, 1'b1);
    check_transfer(1, w, 1'b0, 1'b0, '0, 0);
  endtask

  task automatic test_async_reset;
    logic [4:0] obs;
    logic [W-1:0] w;
    w = $urandom | 32'h0000_0040;
    accept(0, w, 1'b0);
    repeat (6) @(negedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    obs = {so[0], st[0], busy[0], wready[0], done[0]};
    checks++;
    if (obs !== 5'b00010) begin
      errors++;
      $display("FAIL async_reset got=%b want=00010", obs);
    end
    @(negedge clk);
    clr_n = 1'b1;
    check_idle(0, 40, "after_async_reset");
    w = $urandom;
    accept(0, w, 1'b0);
    check_transfer(0, w, 1'b0, 1'b0, '0, 0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      wdata[s]   = '0;
      wvalid[s]  = 1'b0;
      abort_s[s] = 1'b0;
      done_cyc[s] = 0;
    end
    test_reset;
    test_single;
    test_div3;
    test_random;
    test_valid_held;
    test_back_to_back;
    test_abort;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/reg_serial_tx.md
Name: reg_serial_tx

Overview:
- Transmit side of the processor's 32-bit register load interface.
- Accepts a parallel word on a valid/ready handshake and shifts it out one bit at a time, with a strobe per bit.
- Sits between the register file / memory-mapped I/O and any serial consumer, e.g. a debug link or a peripheral shift-in register.
- Counterpart to the parallel-load register: that block captures a word; this block drains one.

Parameters:
WIDTH, 32, word width in bits (>= 2)
DIV, 1, clock cycles each bit is held on serial_out (>= 1)
LSB_FIRST, 1, 1 = bit 0 transmitted first, 0 = bit WIDTH-1 first

Ports:
clk  input  1  single clock, rising edge
clr_n  input  1  asynchronous, active-low reset
write_data  input  WIDTH  word to transmit
write_valid  input  1  write_data is valid
write_ready  output  1  block can accept a word
abort  input  1  synchronous cancel of the current transfer
serial_out  output  1  current serial bit
bit_strobe  output  1  one-cycle pulse on the first cycle of each bit
busy  output  1  transfer in progress
done  output  1  one-cycle pulse when a transfer completes normally

Behaviour:
- Clocking and reset: one clock, clk. Reset clr_n is asynchronous and active-low.
- While clr_n = 0:
  - state = IDLE, shift register = 0, bit and divide counters = 0.
  - serial_out = 0, bit_strobe = 0, busy = 0, done = 0.
  - write_ready = 1, since it is decoded from state.
  - Reset mid-transfer discards the word; no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - write_ready = 1, busy = 0, serial_out = 0.
  - On write_valid & write_ready at edge k: latch write_data, go to SHIFT.
  - After edge k: serial_out = first bit, bit_strobe = 1, busy = 1.
- SHIFT:
  - write_ready = 0; write_valid is ignored.
  - Each bit is held DIV cycles; bit_strobe is high only on the first of those cycles.
  - After the DIV-th cycle of bit WIDTH-1, go to DONE.
  - Total time in SHIFT = WIDTH*DIV cycles.
- DONE (one cycle):
  - done = 1, busy = 0, serial_out = 0, write_ready = 1.
  - A word offered in this cycle is accepted (back-to-back). Next state is SHIFT if accepted, otherwise IDLE.
  - The back-to-back gap on serial_out is exactly one cycle.
- Bit order:
  - LSB_FIRST = 1: bit i goes out at cycle k+1+i*DIV.
  - LSB_FIRST = 0: bit WIDTH-1-i goes out at cycle k+1+i*DIV.
- Abort:
  - abort = 1 in SHIFT: next edge goes to IDLE with serial_out = 0, no done, no further strobes.
  - abort in IDLE or DONE has no effect on state. A handshake in the same cycle as abort in IDLE is still accepted.
  - Abort has priority over the final-bit transition to DONE.
- All outputs are registered except write_ready and busy, which are decoded from state.
- Counters:
  - Bit counter width is clog2(WIDTH); divide counter width is clog2(DIV), minimum 1.
  - Neither counter may wrap past its terminal value.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2; 2'd3 is illegal and recovers to IDLE.
  - default constants for WIDTH and DIV.
- One natural sub-module, reg_serial_bit_timer:
  - contains the DIV divide counter;
  - produces bit_strobe and the bit-advance pulse;
  - is cleared on accept and on abort.
- Shift register and FSM live in reg_serial_tx.

Test Plan:
- Reset, then single word 32'hA5A5_0F0F, DIV=1, LSB_FIRST=1 -> serial_out over cycles k+1..k+32 = 1,1,1,1,0,0,0,0,...; 32 strobes; done at k+33; write_ready low k+1..k+32.
- DIV=3, LSB_FIRST=0, word 32'h8000_0001 -> serial_out 1 for 3 cycles, then 0 for 90, then 1 for 3; strobe every 3rd cycle; done at k+97.
- Back-to-back: second word 32'hFFFF_FFFF held valid during DONE -> accepted that cycle; serial_out low one cycle, then 32 ones; two done pulses 33 cycles apart.
- Abort after 10 bits of 32'h1234_5678 -> next cycle IDLE, serial_out 0, busy 0, no done; a new word is then accepted normally.
- clr_n low asynchronously mid-SHIFT (between edges) -> serial_out, busy and bit_strobe go 0 immediately; write_ready 1; no done after release.
- write_valid held high throughout SHIFT with changing write_data -> transmitted bits unchanged, matching the word latched at accept.
